// File: rtl/mpu_seq_ctrl.sv
// mpu_seq_ctrl -- sequencer for a small output-stationary systolic array.
//
// Accepts one matrix job (A: SA_ROWS x SA_COLS, B: SA_COLS x SA_COLS).
// It streams SA_COLS operand beats into the array, where beat k carries
// column k of A and row k of B. It then collects SA_ROWS result rows,
// which arrive last row first. Finally it presents the assembled C matrix.
// A watchdog ends the drain phase if the array stops returning rows.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_a/b   job command (A[i][k], B[k][j] packed row-major)
//   sa_in_valid/sa_in_ready        operand beat handshake toward the array
//   sa_in_a[i], sa_in_b[j]         A[i][k], B[k][j] for the current beat k
//   sa_in_c[j]                     partial-sum injection, always zero
//   sa_out_valid/sa_out_ready      result row handshake from the array
//   sa_out_c[j]                    one result row
//   res_valid/res_ready, res_c     job result, C[i][j] packed row-major
//   res_err                        job ended by watchdog (qualified by res_valid)
//   busy                           any state other than IDLE

// Per-column result storage: one C column, written one row at a time.
module mpu_seq_col #(
    parameter int SA_ROWS   = 2,
    parameter int OUT_WIDTH = 16,
    parameter int RW        = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               wr,
    input  logic [RW-1:0]                      row,
    input  logic [OUT_WIDTH-1:0]               din,
    output logic [SA_ROWS-1:0][OUT_WIDTH-1:0]  col
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            col <= '0;
        else if (clr)
            col <= '0;
        else if (wr)
            col[row] <= din;
    end
endmodule

module mpu_seq_ctrl #(
    parameter int IN_WIDTH    = 4,
    parameter int OUT_WIDTH   = 16,
    parameter int SA_ROWS     = 2,
    parameter int SA_COLS     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [SA_ROWS*SA_COLS*IN_WIDTH-1:0]     cmd_a,
    input  logic [SA_COLS*SA_COLS*IN_WIDTH-1:0]     cmd_b,
    output logic                                    sa_in_valid,
    input  logic                                    sa_in_ready,
    output logic [SA_ROWS-1:0][IN_WIDTH-1:0]        sa_in_a,
    output logic [SA_COLS-1:0][IN_WIDTH-1:0]        sa_in_b,
    output logic [SA_COLS-1:0][OUT_WIDTH-1:0]       sa_in_c,
    input  logic                                    sa_out_valid,
    output logic                                    sa_out_ready,
    input  logic [SA_COLS-1:0][OUT_WIDTH-1:0]       sa_out_c,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [SA_ROWS*SA_COLS*OUT_WIDTH-1:0]    res_c,
    output logic                                    res_err,
    output logic                                    busy
);
    localparam int KW = (SA_COLS > 1) ? $clog2(SA_COLS) : 1;
    localparam int RW = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [KW-1:0] K_LAST  = KW'(SA_COLS - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(SA_ROWS - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                             state;
    logic [KW-1:0]                          k;
    logic [RW-1:0]                          r;
    logic [WW-1:0]                          wd;
    logic [SA_ROWS*SA_COLS*IN_WIDTH-1:0]    a_q;
    logic [SA_COLS*SA_COLS*IN_WIDTH-1:0]    b_q;
    logic                                   err_q;
    logic                                   accept;
    logic                                   row_wr;
    logic [SA_COLS-1:0][SA_ROWS-1:0][OUT_WIDTH-1:0] col_q;

    assign cmd_ready    = (state == S_IDLE);
    assign sa_in_valid  = (state == S_FEED);
    assign sa_out_ready = (state == S_DRAIN);
    assign res_valid    = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign res_err      = err_q;

    assign accept = cmd_ready && cmd_valid;
    assign row_wr = sa_out_ready && sa_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            k     <= '0;
            r     <= '0;
            wd    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    a_q   <= cmd_a;
                    b_q   <= cmd_b;
                    k     <= '0;
                    r     <= R_LAST;
                    wd    <= '0;
                    err_q <= 1'b0;
                    state <= S_FEED;
                end
                S_FEED: if (sa_in_ready) begin
                    // k holds at its last value rather than wrapping
                    if (k == K_LAST) state <= S_DRAIN;
                    else             k     <= k + 1'b1;
                end
                S_DRAIN: begin
                    // an accepted row takes priority over watchdog expiry
                    if (sa_out_valid) begin
                        wd <= '0;
                        if (r == '0) state <= S_DONE;
                        else         r     <= r - 1'b1;
                    end else if (wd == WD_LAST) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: if (res_ready) state <= S_IDLE;
            endcase
        end
    end

    genvar i, j;
    generate
        for (i = 0; i < SA_ROWS; i++) begin : g_a
            assign sa_in_a[i] = a_q[(i*SA_COLS + int'(k))*IN_WIDTH +: IN_WIDTH];
        end
        for (j = 0; j < SA_COLS; j++) begin : g_col
            assign sa_in_b[j] = b_q[(int'(k)*SA_COLS + j)*IN_WIDTH +: IN_WIDTH];
            assign sa_in_c[j] = '0;

            mpu_seq_col #(
                .SA_ROWS   (SA_ROWS),
                .OUT_WIDTH (OUT_WIDTH),
                .RW        (RW)
            ) u_col (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (accept),
                .wr    (row_wr),
                .row   (r),
                .din   (sa_out_c[j]),
                .col   (col_q[j])
            );

            for (i = 0; i < SA_ROWS; i++) begin : g_res
                assign res_c[(i*SA_COLS + j)*OUT_WIDTH +: OUT_WIDTH] = col_q[j][i];
            end
        end
    endgenerate
endmodule

// File: doc/mpu_seq_ctrl.md
MPU_SEQ_CTRL -- requirements
Module: mpu_seq_ctrl

Interface
REQ-001 SHALL have parameters: IN_WIDTH, default 4, element width of A/B; OUT_WIDTH, default 16, element width of C; SA_ROWS, default 2, array rows; SA_COLS, default 2, array cols and K depth; TIMEOUT_CYC, default 64, drain watchdog limit.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  job command handshake.
REQ-005 cmd_a  input  SA_ROWS*SA_COLS*IN_WIDTH  A[i][k] at bit offset (i*SA_COLS+k)*IN_WIDTH.
REQ-006 cmd_b  input  SA_COLS*SA_COLS*IN_WIDTH  B[k][j] at bit offset (k*SA_COLS+j)*IN_WIDTH.
REQ-007 sa_in_valid / sa_in_ready  output / input  1 / 1  beat handshake toward the array.
REQ-008 sa_in_a_0..SA_ROWS-1  output  IN_WIDTH each.
REQ-009 sa_in_b_0..SA_COLS-1  output  IN_WIDTH each.
REQ-010 sa_in_c_0..SA_COLS-1  output  OUT_WIDTH each; constant 0.
REQ-011 sa_out_valid / sa_out_ready  input / output  1 / 1  result-row handshake from the array.
REQ-012 sa_out_c_0..SA_COLS-1  input  OUT_WIDTH each  one result row.
REQ-013 res_valid / res_ready  output / input  1 / 1  job result handshake.
REQ-014 res_c  output  SA_ROWS*SA_COLS*OUT_WIDTH  C[i][j] at bit offset (i*SA_COLS+j)*OUT_WIDTH.
REQ-015 res_err  output  1  job ended by watchdog; qualified by res_valid.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM SHALL have states IDLE, FEED, DRAIN, DONE.
REQ-018 IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_a/cmd_b, clear beat counter k, set row counter r=SA_ROWS-1, clear watchdog and the res_c/res_err registers, and go to FEED.
REQ-019 cmd_ready SHALL be 0 in FEED, DRAIN, and DONE.
REQ-020 FEED: sa_in_valid=1, sa_in_a_i=A[i][k], sa_in_b_j=B[k][j].
REQ-021 FEED: operands SHALL stay stable while sa_in_ready=0.
REQ-022 FEED: k increments on each sa_in_valid&&sa_in_ready; the beat with k=SA_COLS-1 moves the FSM to DRAIN.
REQ-023 sa_in_valid SHALL be 0 outside FEED.
REQ-024 Latency: the first sa_in_valid SHALL be the cycle after cmd acceptance; with sa_in_ready=1, FEED lasts exactly SA_COLS cycles.
REQ-025 DRAIN: sa_out_ready=1. Each sa_out_valid beat writes sa_out_c_j into C[r][j] and decrements r (rows return last row first).
REQ-026 DRAIN: the beat with r=0 moves the FSM to DONE with res_err=0.
REQ-027 sa_out_ready SHALL be 0 outside DRAIN; array beats outside DRAIN are not consumed.
REQ-028 Watchdog: counts cycles in DRAIN, cleared on each accepted row. Reaching TIMEOUT_CYC-1 with no beat in that cycle moves the FSM to DONE with res_err=1; unfilled rows read 0.
REQ-029 If a row is accepted in the same cycle the watchdog expires, the row wins and the watchdog is not triggered.
REQ-030 DONE: res_valid=1, with res_c/res_err held stable. res_valid&&res_ready moves the FSM to IDLE; a new command can be accepted no earlier than the following cycle.
REQ-031 Counters SHALL be sized $clog2 of their range and SHALL not wrap; no arithmetic is performed on data.

Reset
REQ-032 On reset low, asynchronously: state=IDLE, cmd_ready=1, sa_in_valid=0, sa_out_ready=0, res_valid=0, res_err=0, busy=0, res_c=0, all counters and latched operands=0.
REQ-033 Reset asserted mid-job SHALL abort the job without emitting res_valid; the next job after release SHALL behave as from power-up.

Verification
REQ-034 A=[[1,2],[3,4]], B=I, array returns rows [3,4] then [1,2] -> beats (a0,a1,b0,b1) = (1,3,1,0) then (2,4,0,1); res_c: C00=1, C01=2, C10=3, C11=4; res_err=0.
REQ-035 A and B all 15 -> every C element = 450; no truncation at OUT_WIDTH=16.
REQ-036 sa_in_ready low for 3 cycles during beat 0 -> operands held at (1,3,1,0); exactly 2 beats transferred; result unchanged.
REQ-037 Array never asserts sa_out_valid -> res_valid with res_err=1 after 64 DRAIN cycles; res_c=0.
REQ-038 res_ready held low 10 cycles in DONE -> res_valid and res_c stable; cmd_ready=0 throughout; sa_in_valid not reasserted.
REQ-039 reset pulsed low during FEED beat 1 -> all outputs reach reset values immediately; no res_valid; the next job completes correctly.
